mc_ctrl: RTL

Multi-cycle main controller for the P5 datapath. It decodes the latched instruction fields and walks a FETCH/DECODE/EXE/MEM/WB state machine. On each cycle it drives the datapath write-enables, the mux selects and the 3-bit `ALUOp` that the ALU consumes. It also reads the ALU `Zero` flag back to resolve `beq`.

---
 rtl/mc_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXE/MEM/WB walk that drives datapath
// write-enables, mux selects and ALUOp from the latched Op/Funct fields.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic [1:0] ExtOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSrc,
    output logic       Done,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t st, nxt;

    logic r_type, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, to_exe;
    logic pcwr_c, irwr_c, regwr_c, memwr_c, done_c;

    assign r_type  = (Op == 6'b000000);
    assign is_addu = r_type && (Funct == 6'b100001);
    assign is_subu = r_type && (Funct == 6'b100011);
    assign is_jr   = r_type && (Funct == 6'b001000);
    assign is_ori  = (Op == 6'b001101);
    assign is_lui  = (Op == 6'b001111);
    assign is_lw   = (Op == 6'b100011);
    assign is_sw   = (Op == 6'b101011);
    assign is_beq  = (Op == 6'b000100);
    assign is_j    = (Op == 6'b000010);
    assign is_jal  = (Op == 6'b000011);
    assign to_exe  = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= FETCH;
        else        st <= nxt;
    end

    always_comb begin
        nxt      = FETCH;
        pcwr_c   = 1'b0;
        irwr_c   = 1'b0;
        regwr_c  = 1'b0;
        memwr_c  = 1'b0;
        done_c   = 1'b0;
        ALUOp    = 3'b000;
        ALUSrcB  = 1'b0;
        ExtOp    = 2'b00;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        PCSrc    = 2'b00;

        // ALU controls stay at their EXE values through MEM/WB; Op/Funct are stable.
        if (st == EXE || st == MEM || st == WB) begin
            if (is_addu)             ALUOp = 3'b010;
            else if (is_subu)        ALUOp = 3'b011;
            else if (is_ori)         begin ALUOp = 3'b001; ALUSrcB = 1'b1; end
            else if (is_lui)         begin ALUOp = 3'b001; ALUSrcB = 1'b1; ExtOp = 2'b10; end
            else if (is_lw || is_sw) begin ALUOp = 3'b010; ALUSrcB = 1'b1; ExtOp = 2'b01; end
            else if (is_beq)         ALUOp = 3'b011;
        end

        case (st)
            FETCH: begin
                irwr_c = 1'b1;
                pcwr_c = 1'b1;
                nxt    = DECODE;
            end
            DECODE: begin
                if (is_j) begin
                    pcwr_c = 1'b1; PCSrc = 2'b10; done_c = 1'b1;
                end else if (is_jal) begin
                    pcwr_c = 1'b1; PCSrc = 2'b10; regwr_c = 1'b1;
                    RegDst = 2'b10; MemtoReg = 2'b10; done_c = 1'b1;
                end else if (is_jr) begin
                    pcwr_c = 1'b1; PCSrc = 2'b11; done_c = 1'b1;
                end else if (to_exe) begin
                    nxt = EXE;
                end else begin
                    done_c = 1'b1;
                end
            end
            EXE: begin
                if (is_beq) begin
                    pcwr_c = Zero; PCSrc = 2'b01; done_c = 1'b1;
                end else if (is_lw || is_sw) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                if (is_lw) begin
                    nxt = WB;
                end else begin
                    memwr_c = 1'b1; done_c = 1'b1;
                end
            end
            WB: begin
                regwr_c  = 1'b1;
                done_c   = 1'b1;
                RegDst   = r_type ? 2'b01 : 2'b00;
                MemtoReg = is_lw  ? 2'b01 : 2'b00;
            end
            default: nxt = FETCH;
        endcase
    end

    // Reset low masks the enables at once, even though state is already FETCH.
    assign PCWr  = pcwr_c  & reset;
    assign IRWr  = irwr_c  & reset;
    assign RegWr = regwr_c & reset;
    assign MemWr = memwr_c & reset;
    assign Done  = done_c  & reset;
    assign State = st;

endmodule
